// File: rtl/step_loader_if.sv
// Byte-stream input and step-word output handshakes of the tiny86 step loader.
// The loader uses the slave side; the producer/consumer pair uses the master side.
interface step_loader_if #(
  parameter int STEP_BITS = 656
);
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 step_valid;
  logic [STEP_BITS-1:0] step;
  logic                 step_ready;

  modport master (
    output in_valid, in_data, in_last, step_ready,
    input  in_ready, step_valid, step
  );

  modport slave (
    input  in_valid, in_data, in_last, step_ready,
    output in_ready, step_valid, step
  );
endinterface

// File: rtl/step_loader.sv
// Deserializes the tiny86 trace byte stream into STEP_BITS-wide step words behind
// an output register; malformed frames are dropped and the stream resynchronized.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_ASSEMBLE | accepting frame bytes into the assembly buffer
//   ST_HOLD     | complete frame parked in buffer, waiting for output slot
//   ST_RESYNC   | overlong frame seen, dropping bytes until in_last
module step_loader #(
  parameter int STEP_BITS = 656,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  step_loader_if.slave     bus,
  output logic             err_framing,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      steps_out
);

  localparam int STEP_BYTES = STEP_BITS / 8;
  localparam int CNT_W      = $clog2(STEP_BYTES);
  localparam int IDX_W      = $clog2(STEP_BITS);

  typedef enum logic [1:0] {
    ST_ASSEMBLE = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RESYNC   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STEP_BITS-1:0] buf_q, buf_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 step_valid_q, step_valid_d;
  logic                 err_q, err_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic [31:0]          steps_out_q, steps_out_d;

  logic                 in_ready;
  logic                 accept;
  logic                 drain;
  logic                 last_slot;
  logic [IDX_W-1:0]     byte_off;
  logic [STEP_BITS-1:0] frame_word;

  assign in_ready  = (state_q != ST_HOLD);
  assign accept    = bus.in_valid && in_ready;
  assign drain     = step_valid_q && bus.step_ready;
  assign last_slot = (cnt_q == CNT_W'(STEP_BYTES - 1));
  assign byte_off  = IDX_W'({cnt_q, 3'b000});

  // Buffer with the incoming byte merged in, so a completing frame can load directly.
  always_comb begin
    frame_word                = buf_q;
    frame_word[byte_off +: 8] = bus.in_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    step_d       = step_q;
    step_valid_d = step_valid_q;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    steps_out_d  = steps_out_q;

    if (drain) begin
      step_valid_d = 1'b0;
      steps_out_d  = steps_out_q + 32'd1;
    end

    case (state_q)
      ST_ASSEMBLE: begin
        if (accept) begin
          if (!last_slot) begin
            if (bus.in_last) begin
              buf_d = '0;
              cnt_d = '0;
              err_d = 1'b1;
            end else begin
              buf_d = frame_word;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (!bus.in_last) begin
            buf_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end else begin
            cnt_d = '0;
            if (!step_valid_q || bus.step_ready) begin
              step_d       = frame_word;
              step_valid_d = 1'b1;
              buf_d        = '0;
            end else begin
              buf_d   = frame_word;
              state_d = ST_HOLD;
            end
          end
        end
      end

      // step_valid is necessarily set here, so step_ready alone frees the slot.
      ST_HOLD: begin
        if (bus.step_ready) begin
          step_d       = buf_q;
          step_valid_d = 1'b1;
          buf_d        = '0;
          state_d      = ST_ASSEMBLE;
        end
      end

      ST_RESYNC: begin
        if (accept && bus.in_last) begin
          cnt_d   = '0;
          state_d = ST_ASSEMBLE;
        end
      end

      default: begin
        cnt_d   = '0;
        buf_d   = '0;
        state_d = ST_ASSEMBLE;
      end
    endcase

    if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ASSEMBLE;
      cnt_q        <= '0;
      buf_q        <= '0;
      step_q       <= '0;
      step_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      steps_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      steps_out_q  <= steps_out_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.step_valid = step_valid_q;
  assign bus.step       = step_q;
  assign err_framing    = err_q;
  assign err_count      = err_count_q;
  assign steps_out      = steps_out_q;

endmodule
